// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types, screen geometry and coordinate helpers
package game_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    SLASHING = 2'd2,
    COOLDOWN = 2'd3
  } slash_state_t;

  typedef enum logic [1:0] {
    DIR_POS_X = 2'd0,
    DIR_NEG_X = 2'd1,
    DIR_POS_Y = 2'd2,
    DIR_NEG_Y = 2'd3
  } dir_t;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Keep out-of-range cursor values on screen so speed stays bounded.
  function automatic logic [COORD_W-1:0] clamp_x(input logic [COORD_W-1:0] v);
    return (v > COORD_W'(SCREEN_W - 1)) ? COORD_W'(SCREEN_W - 1) : v;
  endfunction

  function automatic logic [COORD_W-1:0] clamp_y(input logic [COORD_W-1:0] v);
    return (v > COORD_W'(SCREEN_H - 1)) ? COORD_W'(SCREEN_H - 1) : v;
  endfunction

endpackage

// File: rtl/slash_trail_buf.sv
// rtl/slash_trail_buf.sv - ring buffer of recent cursor points with registered read port
module slash_trail_buf #(
  parameter int TRAIL_DEPTH = 8,
  parameter int COORD_W     = 10
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           wr_en,
  input  logic                           clr,
  input  logic [COORD_W-1:0]             wr_x,
  input  logic [COORD_W-1:0]             wr_y,
  input  logic [$clog2(TRAIL_DEPTH)-1:0] rd_idx,
  output logic [COORD_W-1:0]             rd_x,
  output logic [COORD_W-1:0]             rd_y,
  output logic                           rd_valid
);

  localparam int AW = $clog2(TRAIL_DEPTH);

  logic [COORD_W-1:0]     x_mem [TRAIL_DEPTH];
  logic [COORD_W-1:0]     y_mem [TRAIL_DEPTH];
  logic [TRAIL_DEPTH-1:0] valid_q;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_addr;

  // Index 0 is the most recently written point; wraps naturally at power-of-2 depth.
  assign rd_addr = wr_ptr - AW'(1) - rd_idx;

  // Point storage; contents only matter where valid_q is set, so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      x_mem[wr_ptr] <= wr_x;
      y_mem[wr_ptr] <= wr_y;
    end
  end

  // Write pointer and per-entry valid flags; clear wins over a coincident write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      wr_ptr  <= '0;
    end else if (clr) begin
      valid_q <= '0;
      wr_ptr  <= '0;
    end else if (wr_en) begin
      valid_q[wr_ptr] <= 1'b1;
      wr_ptr          <= wr_ptr + AW'(1);
    end
  end

  // Registered read port: one cycle from rd_idx to data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_x     <= '0;
      rd_y     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_x     <= x_mem[rd_addr];
      rd_y     <= y_mem[rd_addr];
      rd_valid <= valid_q[rd_addr];
    end
  end

endmodule

// File: rtl/slash_detector.sv
// rtl/slash_detector.sv - qualifies mouse motion into a slash level; SLASH_DIRECTION_EN adds slash_dir
module slash_detector
  import game_pkg::*;
#(
  parameter int SPEED_TH      = 8,
  parameter int HOLD_SAMPLES  = 2,
  parameter int DECAY_SAMPLES = 3,
  parameter int TRAIL_DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           moveclk,
  input  logic [COORD_W-1:0]             mousex,
  input  logic [COORD_W-1:0]             mousey,
  input  logic                           mousebtn,
  output logic                           slash,
  output logic [10:0]                    speed,
  input  logic [$clog2(TRAIL_DEPTH)-1:0] trail_idx,
  output logic [COORD_W-1:0]             trail_x,
  output logic [COORD_W-1:0]             trail_y,
  output logic                           trail_valid
`ifdef SLASH_DIRECTION_EN
  ,
  output logic [1:0]                     slash_dir
`endif
);

  localparam logic [10:0] SPEED_TH_C = 11'(SPEED_TH);
  localparam logic [3:0]  HOLD_C     = 4'(HOLD_SAMPLES);
  localparam logic [3:0]  DECAY_C    = 4'(DECAY_SAMPLES);

  slash_state_t       state;
  logic               mv_q;
  logic               tick;
  logic [COORD_W-1:0] cx, cy;
  logic [COORD_W-1:0] prev_x, prev_y;
  logic               prev_valid;
  logic [COORD_W-1:0] dx_abs, dy_abs;
  logic [11:0]        speed_sum;
  logic [10:0]        speed_sat;
  logic               active_tick;
  logic               is_fast;
  logic               enter_slash;
  logic               fast_in_slash;
  logic [3:0]         fast_cnt;
  logic [3:0]         slow_cnt;

  assign cx        = clamp_x(mousex);
  assign cy        = clamp_y(mousey);
  assign dx_abs    = abs_diff(cx, prev_x);
  assign dy_abs    = abs_diff(cy, prev_y);
  assign speed_sum = {2'b00, dx_abs} + {2'b00, dy_abs};

  // Saturating Manhattan speed; the first sample after a press has no reference point.
  always_comb begin
    speed_sat = '0;
    if (prev_valid) begin
      speed_sat = (speed_sum > 12'd2047) ? 11'h7FF : speed_sum[10:0];
    end
  end

  // A tick in IDLE is swallowed by the press transition.
  assign active_tick   = tick && mousebtn && (state != IDLE);
  assign is_fast       = (speed_sat >= SPEED_TH_C);
  assign enter_slash   = active_tick && (state == ARMED) && is_fast && (fast_cnt + 4'd1 == HOLD_C);
  assign fast_in_slash = active_tick && (state == SLASHING) && is_fast;

  // Registered rising-edge detector on the motion tick level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mv_q <= 1'b0;
      tick <= 1'b0;
    end else begin
      mv_q <= moveclk;
      tick <= moveclk & ~mv_q;
    end
  end

  // Slash qualification FSM; release overrides everything, including a tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      slash      <= 1'b0;
      speed      <= '0;
      fast_cnt   <= '0;
      slow_cnt   <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_valid <= 1'b0;
    end else if (!mousebtn) begin
      state      <= IDLE;
      slash      <= 1'b0;
      fast_cnt   <= '0;
      slow_cnt   <= '0;
      prev_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state      <= ARMED;
          fast_cnt   <= '0;
          prev_valid <= 1'b0;
        end
        ARMED: begin
          if (tick) begin
            if (enter_slash) begin
              state    <= SLASHING;
              slash    <= 1'b1;
              slow_cnt <= '0;
            end else if (is_fast) begin
              fast_cnt <= fast_cnt + 4'd1;
            end else begin
              fast_cnt <= '0;
            end
          end
        end
        SLASHING: begin
          if (tick) begin
            if (is_fast) begin
              slow_cnt <= '0;
            end else if (slow_cnt + 4'd1 == DECAY_C) begin
              state <= COOLDOWN;
              slash <= 1'b0;
            end else begin
              slow_cnt <= slow_cnt + 4'd1;
            end
          end
        end
        COOLDOWN: begin
          slash <= 1'b0;
        end
        default: begin
          state <= IDLE;
          slash <= 1'b0;
        end
      endcase
      if (active_tick) begin
        prev_x     <= cx;
        prev_y     <= cy;
        prev_valid <= 1'b1;
        speed      <= speed_sat;
      end
    end
  end

`ifdef SLASH_DIRECTION_EN
  dir_t dir_now;

  // Dominant axis sign of the current motion; ties go to x.
  always_comb begin
    dir_now = DIR_POS_X;
    if (dx_abs >= dy_abs) begin
      dir_now = (cx >= prev_x) ? DIR_POS_X : DIR_NEG_X;
    end else begin
      dir_now = (cy >= prev_y) ? DIR_POS_Y : DIR_NEG_Y;
    end
  end

  // Direction is captured on SLASHING entry and tracked on every fast tick there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slash_dir <= 2'd0;
    end else if (enter_slash || fast_in_slash) begin
      slash_dir <= dir_now;
    end
  end
`endif

  slash_trail_buf #(
    .TRAIL_DEPTH(TRAIL_DEPTH),
    .COORD_W    (COORD_W)
  ) u_trail (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (active_tick),
    .clr     (~mousebtn),
    .wr_x    (cx),
    .wr_y    (cy),
    .rd_idx  (trail_idx),
    .rd_x    (trail_x),
    .rd_y    (trail_y),
    .rd_valid(trail_valid)
  );

endmodule

// File: tb/tb_slash_detector.sv
// tb/tb_slash_detector.sv - scoreboard testbench for slash_detector
module tb_slash_detector;
  import game_pkg::*;

  localparam int SEL_SLASH  = 0;
  localparam int SEL_SPEED  = 1;
  localparam int SEL_TX     = 2;
  localparam int SEL_TY     = 3;
  localparam int SEL_TVALID = 4;
  localparam int SEL_STATE  = 5;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       moveclk = 1'b0;
  logic [9:0] mousex = '0;
  logic [9:0] mousey = '0;
  logic       mousebtn = 1'b0;
  logic       slash;
  logic [10:0] speed;
  logic [2:0] trail_idx = '0;
  logic [9:0] trail_x;
  logic [9:0] trail_y;
  logic       trail_valid;
`ifdef SLASH_DIRECTION_EN
  logic [1:0] slash_dir;
`endif

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   slashed_seen = 1'b0;

  always #5 clk = ~clk;

  slash_detector dut (
    .clk        (clk),
    .rstn       (rstn),
    .moveclk    (moveclk),
    .mousex     (mousex),
    .mousey     (mousey),
    .mousebtn   (mousebtn),
    .slash      (slash),
    .speed      (speed),
    .trail_idx  (trail_idx),
    .trail_x    (trail_x),
    .trail_y    (trail_y),
    .trail_valid(trail_valid)
`ifdef SLASH_DIRECTION_EN
    ,
    .slash_dir  (slash_dir)
`endif
  );

  function automatic int actual(input int sel);
    case (sel)
      SEL_SLASH:  return int'(slash);
      SEL_SPEED:  return int'(speed);
      SEL_TX:     return int'(trail_x);
      SEL_TY:     return int'(trail_y);
      SEL_TVALID: return int'(trail_valid);
      default:    return int'(dut.state);
    endcase
  endfunction

  task automatic expect_val(input string name, input int sel, input int exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Monitor: drains pending expectations away from the active clock edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      int   a;
      e = sb.pop_front();
      a = actual(e.sel);
      n_vec++;
      if (a != e.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d expected %0d at %0t", e.name, a, e.exp, $time);
      end
    end
  end

  task automatic do_tick(input int x, input int y);
    @(posedge clk); #1;
    mousex  = 10'(x);
    mousey  = 10'(y);
    moveclk = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    moveclk = 1'b0;
  endtask

  task automatic press(input int x, input int y);
    @(posedge clk); #1;
    mousex   = 10'(x);
    mousey   = 10'(y);
    mousebtn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic release_btn();
    @(posedge clk); #1;
    mousebtn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    #1 rstn = 1'b0;
    #1;
    expect_val("rst_slash", SEL_SLASH, 0);
    expect_val("rst_speed", SEL_SPEED, 0);
    expect_val("rst_tvalid", SEL_TVALID, 0);
    expect_val("rst_state", SEL_STATE, int'(IDLE));
    #20 rstn = 1'b1;

    // Basic slash: first tick speed 0, then two 10-pixel moves
    press(100, 100);
    expect_val("press_state", SEL_STATE, int'(ARMED));
    do_tick(110, 100);
    expect_val("t1_speed", SEL_SPEED, 0);
    expect_val("t1_slash", SEL_SLASH, 0);
    do_tick(120, 100);
    expect_val("t2_speed", SEL_SPEED, 10);
    expect_val("t2_slash", SEL_SLASH, 0);
    do_tick(130, 100);
    expect_val("t3_speed", SEL_SPEED, 10);
    expect_val("t3_slash", SEL_SLASH, 1);
    expect_val("t3_state", SEL_STATE, int'(SLASHING));

    // Decay: three slow moves end the slash
    do_tick(134, 100);
    expect_val("d1_slash", SEL_SLASH, 1);
    do_tick(138, 100);
    expect_val("d2_slash", SEL_SLASH, 1);
    do_tick(142, 100);
    expect_val("d3_speed", SEL_SPEED, 4);
    expect_val("d3_slash", SEL_SLASH, 0);
    expect_val("d3_state", SEL_STATE, int'(COOLDOWN));
    do_tick(160, 100);
    expect_val("cd1_speed", SEL_SPEED, 18);
    expect_val("cd1_slash", SEL_SLASH, 0);
    do_tick(180, 100);
    do_tick(200, 100);
    expect_val("cd3_slash", SEL_SLASH, 0);
    expect_val("cd3_state", SEL_STATE, int'(COOLDOWN));
    release_btn();
    expect_val("rel_state", SEL_STATE, int'(IDLE));
    expect_val("rel_slash", SEL_SLASH, 0);
    expect_val("rel_tvalid", SEL_TVALID, 0);

    // Reset asserted asynchronously while slashing
    press(100, 100);
    do_tick(110, 100);
    do_tick(120, 100);
    do_tick(130, 100);
    expect_val("pre_rst_slash", SEL_SLASH, 1);
    expect_val("pre_rst_tvalid", SEL_TVALID, 1);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    expect_val("arst_slash", SEL_SLASH, 0);
    expect_val("arst_speed", SEL_SPEED, 0);
    expect_val("arst_tvalid", SEL_TVALID, 0);
    mousebtn = 1'b0;
    #20 rstn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_val("arst_state", SEL_STATE, int'(IDLE));

    // Fast/slow/fast must not qualify: a slow tick clears the hold count
    press(0, 0);
    do_tick(0, 0);
    do_tick(20, 0);
    do_tick(21, 0);
    do_tick(41, 0);
    expect_val("broken_slash", SEL_SLASH, 0);
    expect_val("broken_speed", SEL_SPEED, 20);
    do_tick(61, 0);
    expect_val("hold_slash", SEL_SLASH, 1);
    release_btn();

    // Stationary hold never slashes
    press(300, 200);
    for (int i = 0; i < 20; i++) begin
      do_tick(300, 200);
      expect_val("still_speed", SEL_SPEED, 0);
      if (slash) slashed_seen = 1'b1;
    end
    expect_val("still_slash", SEL_SLASH, 0);
    expect_val("still_state", SEL_STATE, int'(ARMED));
    n_vec++;
    if (slashed_seen) begin
      n_bad++;
      $display("FAIL still_never: slash asserted during stationary hold, expected never");
    end
    release_btn();

    // Full-screen diagonal and forced saturation
    press(0, 0);
    do_tick(0, 0);
    do_tick(639, 479);
    expect_val("diag_speed", SEL_SPEED, 1118);
    force dut.speed_sum = 12'd3000;
    do_tick(639, 479);
    release dut.speed_sum;
    expect_val("sat_speed", SEL_SPEED, 2047);
    release_btn();

    // Trail: ten points x=0..9 into an eight-entry ring
    press(0, 5);
    for (int i = 0; i < 10; i++) begin
      do_tick(i, 5);
    end
    trail_idx = 3'd0;
    @(posedge clk); #1;
    expect_val("trail0_x", SEL_TX, 9);
    expect_val("trail0_y", SEL_TY, 5);
    expect_val("trail0_valid", SEL_TVALID, 1);
    trail_idx = 3'd7;
    @(posedge clk); #1;
    expect_val("trail7_x", SEL_TX, 2);
    expect_val("trail7_valid", SEL_TVALID, 1);
    trail_idx = 3'd3;
    @(posedge clk); #1;
    expect_val("trail3_x", SEL_TX, 6);
    release_btn();
    trail_idx = 3'd0;
    @(posedge clk); #1;
    expect_val("trail_rel0", SEL_TVALID, 0);
    trail_idx = 3'd5;
    @(posedge clk); #1;
    expect_val("trail_rel5", SEL_TVALID, 0);

    @(negedge clk);
    @(posedge clk); #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/slash_detector.md
Name: slash_detector

Overview:
- Input-conditioning stage upstream of the object/fruit state machine.
- Turns raw mouse coordinates and button level into a qualified "slash" level, which feeds the object machine's mousepush input directly.
- A slash requires the button held and cursor speed at or above a threshold for consecutive motion samples, so a stationary click never cuts fruit.
- Also keeps a short ring buffer of recent cursor points for the blade-trail renderer.

Parameters:
- SPEED_TH, 8: minimum Manhattan displacement (pixels per sample) that counts as fast.
- HOLD_SAMPLES, 2: consecutive fast samples needed to enter SLASHING; range 1..15.
- DECAY_SAMPLES, 3: slow samples tolerated in SLASHING before dropping to COOLDOWN; range 1..15.
- TRAIL_DEPTH, 8: trail ring entries; power of 2, range 2..32.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- moveclk  in  1  motion tick level (same signal the motion units use); rising edge detected internally with clk
- mousex  in  10  cursor x, 0..639
- mousey  in  10  cursor y, 0..479
- mousebtn  in  1  raw left-button level, already synchronised
- slash  out  1  qualified cut level; drives the object machine's mousepush
- speed  out  11  last sampled Manhattan speed, saturating at 2047
- trail_idx  in  log2(TRAIL_DEPTH)  read index; 0 = newest point
- trail_x  out  10  x of the addressed point
- trail_y  out  10  y of the addressed point
- trail_valid  out  1  addressed entry holds a point

Behaviour:
- Reset (async, rstn low): slash=0, speed=0, trail_valid=0, state=IDLE, sample counters=0, prev_valid=0, all trail entries invalid.
- Sample tick: one cycle after a rising moveclk edge (registered edge detector). All updates below happen only on the tick, except button release.
- Speed: |x-prev_x| + |y-prev_y|, 11-bit, saturating. prev is updated on every tick while mousebtn=1.
  - On the first tick after a press (prev_valid=0), speed=0.
- States:
  - IDLE: slash=0.
    - mousebtn=1 goes to ARMED, fast_cnt=0, prev_valid=0.
  - ARMED: slash=0.
    - On a tick with speed>=SPEED_TH, fast_cnt increments.
    - On a tick with speed<SPEED_TH, fast_cnt clears.
    - When fast_cnt reaches HOLD_SAMPLES, go to SLASHING. slash=1 is registered on the same clock as that tick.
  - SLASHING: slash=1.
    - A slow tick increments slow_cnt; a fast tick clears it.
    - When slow_cnt reaches DECAY_SAMPLES, go to COOLDOWN and slash=0.
  - COOLDOWN: slash=0.
    - Re-arming requires a button release. The next press goes through IDLE to ARMED.
- Button release: mousebtn=0 in any state goes to IDLE on the next clk with slash=0, regardless of tick. All trail entries are invalidated that same cycle. Release takes priority over a coincident tick.
- Trail buffer:
  - On every tick while mousebtn=1, the current (mousex, mousey) is written at wr_ptr, marked valid, and wr_ptr increments modulo TRAIL_DEPTH. Overflow overwrites the oldest entry silently.
  - Read addresses entry (wr_ptr-1-trail_idx) mod TRAIL_DEPTH.
  - trail_x, trail_y and trail_valid are registered: 1-cycle latency from trail_idx.
- Simultaneous press and tick in IDLE: the transition to ARMED is taken; that tick is ignored for speed and trail.

Optional Feature:
- SLASH_DIRECTION_EN defined: adds output slash_dir[1:0], the dominant axis sign of the last fast sample.
  - Values: 0 = +x, 1 = -x, 2 = +y, 3 = -y. Ties resolve to the x axis.
  - Latched on entry to SLASHING and updated on each fast tick in SLASHING.
  - Reset value 0. Held in other states.
- Not defined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package game_pkg:
  - COORD_W=10, SCREEN_W=640, SCREEN_H=480.
  - slash_state_t enum {IDLE, ARMED, SLASHING, COOLDOWN}.
  - dir_t encoding.
- One sub-module: slash_trail_buf (ring buffer plus registered read port), parameterised by TRAIL_DEPTH and COORD_W.

Test Plan:
- Reset mid-SLASHING: assert rstn low asynchronously between clk edges. Required: slash=0 immediately, speed=0, all trail_valid=0; after release the block is in IDLE.
- Press at (100,100), then ticks at x=110,120,130 with y fixed. Required:
  - First tick speed=0.
  - Then speed=10 twice.
  - slash=1 on the clock of the 2nd fast tick (HOLD_SAMPLES=2).
- Press and hold stationary at (300,200) for 20 ticks. Required: speed=0 every tick, slash never asserts, state stays ARMED.
- In SLASHING, 3 ticks with 4-pixel moves. Required: slash=0 after the 3rd, state COOLDOWN. Further fast moves keep slash=0 until release and re-press.
- Move (0,0) to (639,479) in one tick after prev_valid. Required: speed=1118. Then inject a computed sum above 2047 via force. Required: speed saturates at 2047.
- Trail: 10 ticks held at x=0..9 with TRAIL_DEPTH=8. Required:
  - trail_idx=0 returns x=9 one clock later; trail_idx=7 returns x=2.
  - Release, then any index gives trail_valid=0.
